// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, bubble instruction and fetch FSM state type
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - one-entry instruction+PC parking register used while decode stalls
module fetch_hold_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        drop_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        full_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        full_q, full_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (drop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q  <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC_F, imem handshake, IF/ID register; IFETCH_MISALIGN_TRAP_EN adds misaligned_F
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        pc_src_E,
  input  logic [31:0] pc_target_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D
`ifdef IFETCH_MISALIGN_TRAP_EN
  , output logic      misaligned_F
`endif
);

  import riscv_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  kill_addr_q, kill_addr_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc4_q, id_pc4_d;
  logic         id_valid_q, id_valid_d;
  logic         req_c, load_id;
  logic [31:0]  load_instr, load_pc, target;
  logic         hb_load, hb_drop, hb_full;
  logic [31:0]  hb_instr, hb_pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign target       = pc_target_E;
  assign misaligned_F = mis_q;
`else
  assign target = pc_target_E & ~32'h3;
`endif

  fetch_hold_buffer u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hb_load),
    .drop_i  (hb_drop),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .full_o  (hb_full),
    .instr_o (hb_instr),
    .pc_o    (hb_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    req_c       = 1'b0;
    load_id     = 1'b0;
    load_instr  = imem_rdata;
    load_pc     = pc_q;
    hb_load     = 1'b0;
    hb_drop     = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    mis_d       = mis_q;
`endif
    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (imem_ack) begin
          if (pc_src_E) begin
            pc_d = target;
          end else if (stall_D) begin
            hb_load = 1'b1;
            state_d = HOLD;
          end else begin
            load_id = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end else if (pc_src_E) begin
          pc_d        = target;
          kill_addr_d = pc_q;
          state_d     = KILL;
        end
      end
      HOLD: begin
        if (pc_src_E) begin
          hb_drop = 1'b1;
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_D && hb_full) begin
          hb_drop    = 1'b1;
          load_id    = 1'b1;
          load_instr = hb_instr;
          load_pc    = hb_pc;
          pc_d       = pc_q + 32'd4;
          state_d    = FETCH;
        end
      end
      KILL: begin
        // The stale request must still complete before the new PC is fetched.
        req_c = 1'b1;
        if (pc_src_E) pc_d = target;
        if (imem_ack) state_d = FETCH;
      end
      default: ;
    endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (state_d == FETCH && pc_d[1:0] != 2'b00 && (pc_src_E || state_q == KILL)) begin
      state_d = HALT;
      mis_d   = 1'b1;
    end
`endif
  end

  always_comb begin
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    if (flush_D) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (stall_D) begin
      id_valid_d = id_valid_q;
    end else if (load_id) begin
      id_instr_d = load_instr;
      id_pc_d    = load_pc;
      id_pc4_d   = load_pc + 32'd4;
      id_valid_d = 1'b1;
    end else begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      kill_addr_q <= 32'h0;
      id_instr_q  <= NOP_INSTR;
      id_pc_q     <= 32'h0;
      id_pc4_q    <= 32'h0;
      id_valid_q  <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign imem_req   = req_c & ~reset;
  assign imem_addr  = (state_q == KILL) ? kill_addr_q : pc_q;
  assign instr_D    = id_instr_q;
  assign pc_D       = id_pc_q;
  assign pc_plus4_D = id_pc4_q;
  assign valid_D    = id_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed plus randomized bench for instruction_fetch with a stream-level reference
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, stall_D, flush_D, pc_src_E, imem_ack;
  logic [31:0] pc_target_E, imem_rdata;
  logic        imem_req, valid_D;
  logic [31:0] imem_addr, instr_D, pc_D, pc_plus4_D;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misaligned_F;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: one outstanding request, latency drawn from [lat_min, lat_max].
  logic        busy = 1'b0;
  int          lat = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  logic [31:0] req_addr = 32'h0;

  // Program-order reference: next PC the decoder should see.
  logic [31:0] exp_pc = 32'h0;
  int          deliveries = 0;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .pc_src_E    (pc_src_E),
    .pc_target_E (pc_target_E),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .pc_plus4_D  (pc_plus4_D),
    .valid_D     (valid_D)
`ifdef IFETCH_MISALIGN_TRAP_EN
    , .misaligned_F (misaligned_F)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic ps, input logic [31:0] tgt, input logic fl);
    @(negedge clk);
    stall_D     = st;
    pc_src_E    = ps;
    pc_target_E = tgt;
    flush_D     = fl;
    imem_ack    = 1'b0;
    imem_rdata  = $urandom;
    if (imem_req) begin
      if (!busy) begin
        busy     = 1'b1;
        req_addr = imem_addr;
        lat      = $urandom_range(lat_max, lat_min);
      end else begin
        chk("addr_stable", imem_addr, req_addr);
      end
      if (lat == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(req_addr);
      end else begin
        lat--;
      end
    end
    @(posedge clk);
    if (imem_ack) busy = 1'b0;
    #1;
    if (!st && !fl && valid_D) begin
      deliveries++;
      chk("sb_pc", pc_D, exp_pc);
      chk("sb_instr", instr_D, mem_word(exp_pc));
      chk("sb_pc4", pc_plus4_D, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    if (ps) exp_pc = tgt & ~32'h3;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; stall_D = 1'b0; flush_D = 1'b0; pc_src_E = 1'b0;
    pc_target_E = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", valid_D, 1'b0);
    chk("rst_instr", instr_D, 32'h0000_0013);
    chk("rst_pc", pc_D, 32'h0);
    chk("rst_pc4", pc_plus4_D, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("first_addr", imem_addr, 32'h0);
    chk("first_req", imem_req, 1'b1);

    // Single-cycle memory, two back-to-back instructions.
    step(0, 0, 0, 0);
    chk("i0_instr", instr_D, 32'h00A0_0093);
    chk("i0_pc", pc_D, 32'h0);
    chk("i0_pc4", pc_plus4_D, 32'h4);
    chk("i0_valid", valid_D, 1'b1);
    step(0, 0, 0, 0);
    chk("i1_instr", instr_D, 32'h0010_0113);
    chk("i1_pc", pc_D, 32'h4);

    // Ack at 0x8 under a 3-cycle stall.
    step(1, 0, 0, 0);
    chk("hold_req", imem_req, 1'b0);
    chk("hold_instr", instr_D, 32'h0010_0113);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("hold_req3", imem_req, 1'b0);
    step(0, 0, 0, 0);
    chk("unhold_pc", pc_D, 32'h8);
    chk("unhold_instr", instr_D, mem_word(32'h8));
    chk("unhold_next", imem_addr, 32'hC);
    chk("unhold_req", imem_req, 1'b1);

    // 3-cycle latency with redirect in the first wait cycle.
    lat_min = 2; lat_max = 2;
    step(0, 1, 32'h100, 0);
    chk("kill_addr1", imem_addr, 32'hC);
    chk("kill_valid1", valid_D, 1'b0);
    step(0, 0, 0, 0);
    chk("kill_addr2", imem_addr, 32'hC);
    chk("kill_valid2", valid_D, 1'b0);
    step(0, 0, 0, 0);
    chk("kill_valid3", valid_D, 1'b0);
    chk("kill_next", imem_addr, 32'h100);

    // Redirect plus flush coincident with ack.
    lat_min = 0; lat_max = 0;
    step(0, 1, 32'h40, 1);
    chk("rf_instr", instr_D, 32'h0000_0013);
    chk("rf_valid", valid_D, 1'b0);
    chk("rf_next", imem_addr, 32'h40);
    step(0, 0, 0, 0);
    chk("rf_pc", pc_D, 32'h40);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc4", pc_plus4_D, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);

    // Random traffic against the program-order reference.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      logic st, ps, fl;
      st = ($urandom % 10) < 3;
      ps = ($urandom % 12) == 0;
      fl = ps && ($urandom % 2 == 0);
      r  = $urandom & ~32'h3;
      step(st, ps, r, fl);
    end
    chk("rand_progress", (deliveries > 100) ? 32'h1 : 32'h0, 32'h1);

    // Misaligned redirect target.
    lat_min = 0; lat_max = 0;
    repeat (5) step(0, 0, 0, 0);
    step(0, 1, 32'h102, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("mis_flag", misaligned_F, 1'b1);
    chk("mis_req", imem_req, 1'b0);
    step(0, 0, 0, 0);
    chk("mis_req2", imem_req, 1'b0);
    chk("mis_valid", valid_D, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    busy  = 1'b0;
    imem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("mis_clear", misaligned_F, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mis_restart", imem_addr, 32'h0);
    chk("mis_restart_req", imem_req, 1'b1);
`else
    chk("align_force", imem_addr, 32'h100);
    step(0, 0, 0, 0);
    chk("align_pc", pc_D, 32'h100);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
